// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem
// requests and buffers returned words with their PC in an in-order ring.
module fetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     branch_valid,
    input  logic [XLEN-1:0]          branch_target,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [XLEN-1:0]          instr,
    output logic [XLEN-1:0]          instr_pc,
    output logic [XLEN-1:0]          instr_pc8,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] word_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];

    logic            pop;
    logic            push;
    logic [CW:0]     used;
    logic [CW:0]     limit;

    // A pop in the same cycle releases a slot, so a full queue can still issue.
    always_comb begin
        instr_valid = !reset && !branch_valid && (count_q != '0);
        pop         = instr_valid && instr_ready;
        push        = inflight_q && !branch_valid;
        used        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        limit       = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
        imem_req    = !reset && !branch_valid && (used < limit);
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (branch_valid) begin
            fetch_pc_d = branch_target & ~XLEN'(3);
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d    = fetch_pc_q + XLEN'(4);
                inflight_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            word_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    always_comb begin
        imem_addr = fetch_pc_q & ~XLEN'(3);
        instr     = word_q[rd_ptr_q];
        instr_pc  = pc_q[rd_ptr_q];
        instr_pc8 = instr_pc + XLEN'(8);
        occupancy = reset ? '0 : count_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory returns ~addr; a PC scoreboard checks every
// accepted instruction, scenario tasks check timing and flush behaviour.
module tb_fetch_queue;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc8;
    logic [2:0]  occupancy;

    int vectors;
    int miscompares;
    int pops;
    logic [31:0] sb [$];
    logic [31:0] sb_next;

    fetch_queue #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_pc8(instr_pc8),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= ~imem_addr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard: redirects seed the expected PC stream, every accepted head pops it.
    always @(negedge clk) begin
        if (reset) begin
            vectors++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || occupancy !== 3'd0) begin
                miscompares++;
                $display("FAIL in_reset: req=%b valid=%b occ=%0d required 0/0/0", imem_req, instr_valid, occupancy);
            end
            sb.delete();
            sb_next = RESET_PC;
        end else if (branch_valid) begin
            vectors++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL in_branch: req=%b valid=%b required 0/0", imem_req, instr_valid);
            end
            sb.delete();
            sb_next = branch_target & ~32'd3;
            sb.push_back(sb_next);
            sb_next = sb_next + 32'd4;
        end else if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            logic [31:0] e;
            if (sb.size() == 0) begin
                sb.push_back(sb_next);
                sb_next = sb_next + 32'd4;
            end
            e = sb.pop_front();
            vectors++;
            pops++;
            if (instr_pc !== e || instr !== ~e || instr_pc8 !== e + 32'd8) begin
                miscompares++;
                $display("FAIL sb_pop: pc=%h instr=%h pc8=%h required pc=%h instr=%h pc8=%h",
                         instr_pc, instr, instr_pc8, e, ~e, e + 32'd8);
            end
        end
        if (!reset && imem_req === 1'b1 && imem_addr[1:0] !== 2'b00) begin
            vectors++;
            miscompares++;
            $display("FAIL addr_align: addr=%h required low bits 00", imem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || occupancy !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_state: req=%b valid=%b occ=%0d required 0/0/0", imem_req, instr_valid, occupancy);
            end
            tick();
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e = 32'(4 * c);
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== e) begin
                miscompares++;
                $display("FAIL stream_req c%0d: req=%b addr=%h required 1/%h", c, imem_req, imem_addr, e);
            end
            vectors++;
            if (instr_valid !== (c >= 2)) begin
                miscompares++;
                $display("FAIL stream_valid c%0d: valid=%b required %b", c, instr_valid, c >= 2);
            end
            if (c >= 2) begin
                e = 32'(4 * (c - 2));
                vectors++;
                if (instr_pc !== e) begin
                    miscompares++;
                    $display("FAIL stream_pc c%0d: pc=%h required %h", c, instr_pc, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] e;
        reset = 1'b1; instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                e = 32'(4 * n);
                vectors++;
                if (imem_addr !== e) begin
                    miscompares++;
                    $display("FAIL bp_addr: addr=%h required %h", imem_addr, e);
                end
                n++;
            end
            tick();
        end
        @(negedge clk);
        vectors++;
        if (n != 4 || imem_req !== 1'b0 || occupancy !== 3'd4) begin
            miscompares++;
            $display("FAIL bp_full: reqs=%0d req=%b occ=%0d required 4/0/4", n, imem_req, occupancy);
        end
        tick();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = 32'(4 * k);
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== e) begin
                miscompares++;
                $display("FAIL bp_drain k%0d: valid=%b pc=%h required 1/%h", k, instr_valid, instr_pc, e);
            end
            if (k == 0) begin
                vectors++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                    miscompares++;
                    $display("FAIL bp_credit: req=%b addr=%h required 1/00000010", imem_req, imem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_flush();
        reset = 1'b1; instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        branch_valid = 1'b1; branch_target = 32'h100;
        @(negedge clk);
        vectors++;
        if (occupancy !== 3'd2) begin
            miscompares++;
            $display("FAIL flush_pre: occ=%0d required 2", occupancy);
        end
        tick();
        branch_valid = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0 || occupancy !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_b1: req=%b addr=%h valid=%b occ=%0d required 1/00000100/0/0",
                     imem_req, imem_addr, instr_valid, occupancy);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_b2: valid=%b occ=%0d required 0/0", instr_valid, occupancy);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_pc8 !== 32'h108 || instr !== ~32'h100) begin
            miscompares++;
            $display("FAIL flush_b3: valid=%b pc=%h pc8=%h required 1/00000100/00000108",
                     instr_valid, instr_pc, instr_pc8);
        end
        tick();
    endtask

    task automatic test_branch_pop();
        bit found;
        tick(); tick();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bpop_pre: valid=%b required 1", instr_valid);
        end
        tick();
        branch_valid = 1'b1; branch_target = 32'h203; instr_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL bpop_cycle: valid=%b req=%b required 0/0", instr_valid, imem_req);
        end
        tick();
        branch_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                found = 1'b1;
                vectors++;
                if (instr_pc !== 32'h200 || instr !== ~32'h200) begin
                    miscompares++;
                    $display("FAIL bpop_next: pc=%h instr=%h required 00000200/%h", instr_pc, instr, ~32'h200);
                end
            end
            tick();
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL bpop_timeout: instr_valid never rose, required within 6 cycles");
        end
    endtask

    task automatic test_full_reset();
        reset = 1'b1; instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        vectors++;
        if (occupancy !== 3'd4 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pre: occ=%0d req=%b required 4/0", occupancy, imem_req);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (occupancy !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL full_post: occ=%0d valid=%b req=%b addr=%h required 0/0/1/%h",
                     occupancy, instr_valid, imem_req, imem_addr, RESET_PC);
        end
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL full_refetch: valid=%b pc=%h required 1/%h", instr_valid, instr_pc, RESET_PC);
        end
        tick();
    endtask

    task automatic test_wrap_random();
        logic [31:0] e;
        int pops0;
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFF2; instr_ready = 1'b1;
        tick();
        branch_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e = 32'hFFFF_FFF0 + 32'(4 * c);
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== e) begin
                miscompares++;
                $display("FAIL wrap_addr c%0d: req=%b addr=%h required 1/%h", c, imem_req, imem_addr, e);
            end
            tick();
        end
        pops0 = pops;
        for (int c = 0; c < 1000; c++) begin
            instr_ready  = ($urandom_range(0, 9) < 7);
            branch_valid = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0)
                branch_target = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            else
                branch_target = $urandom;
            tick();
        end
        branch_valid = 1'b0;
        vectors++;
        if (pops - pops0 < 300) begin
            miscompares++;
            $display("FAIL rand_progress: accepted=%0d required >=300", pops - pops0);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; pops = 0;
        reset = 1'b1; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
        test_reset();
        test_backpressure();
        test_branch_flush();
        test_branch_pop();
        test_full_reset();
        test_wrap_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
